// File: rtl/logic_gate_unit.sv
// Registered bitwise logic unit with valid/ready handshake and a built-in
// truth-table sweep that folds all 28 sweep results into a rotating signature.
module logic_gate_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SIG_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             out_err,
  input  logic             sweep_start,
  output logic             sweep_busy,
  output logic             sweep_done,
  output logic [SIG_W-1:0] signature
);

  localparam int unsigned VEC_W = 5;
  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(27);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic               err_q, err_d;
  logic               valid_q, valid_d;
  logic               sweep_res_q, sweep_res_d;
  logic [SIG_W-1:0]   sig_q, sig_d;

  logic               take_c;
  logic               consume_c;
  logic [2:0]         op_sel_c;
  logic [WIDTH-1:0]   a_sel_c;
  logic [WIDTH-1:0]   b_sel_c;
  logic [WIDTH:0]     res_c;

  // Returns {err, y} for one operation.
  function automatic logic [WIDTH:0] gate_f(input logic [2:0] f_op,
                                            input logic [WIDTH-1:0] fa,
                                            input logic [WIDTH-1:0] fb);
    case (f_op)
      3'd0:    gate_f = {1'b0, fa & fb};
      3'd1:    gate_f = {1'b0, fa | fb};
      3'd2:    gate_f = {1'b0, ~fa};
      3'd3:    gate_f = {1'b0, ~(fa & fb)};
      3'd4:    gate_f = {1'b0, ~(fa | fb)};
      3'd5:    gate_f = {1'b0, fa ^ fb};
      3'd6:    gate_f = {1'b0, ~(fa ^ fb)};
      default: gate_f = {1'b1, {WIDTH{1'b0}}};
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    y_d         = y_q;
    err_d       = err_q;
    valid_d     = valid_q;
    sweep_res_d = sweep_res_q;
    sig_d       = sig_q;
    in_ready    = 1'b0;
    sweep_done  = 1'b0;

    take_c    = !valid_q || out_ready;
    consume_c = valid_q && out_ready;

    // Sweep vectors replicate the A/B bits across the whole operand width.
    if (state_q == SWEEP) begin
      op_sel_c = vec_q[4:2];
      a_sel_c  = {WIDTH{vec_q[1]}};
      b_sel_c  = {WIDTH{vec_q[0]}};
    end else begin
      op_sel_c = op;
      a_sel_c  = a;
      b_sel_c  = b;
    end
    res_c = gate_f(op_sel_c, a_sel_c, b_sel_c);

    if (consume_c) begin
      valid_d = 1'b0;
      if (sweep_res_q) begin
        sig_d = {sig_q[SIG_W-2:0], sig_q[SIG_W-1]} ^ SIG_W'(y_q);
      end
    end

    case (state_q)
      IDLE: begin
        in_ready = take_c && !sweep_start;
        if (sweep_start) begin
          state_d = SWEEP;
          vec_d   = '0;
          sig_d   = '0;
        end else if (in_valid && take_c) begin
          y_d         = res_c[WIDTH-1:0];
          err_d       = res_c[WIDTH];
          valid_d     = 1'b1;
          sweep_res_d = 1'b0;
        end
      end
      SWEEP: begin
        if (take_c) begin
          y_d         = res_c[WIDTH-1:0];
          err_d       = res_c[WIDTH];
          valid_d     = 1'b1;
          sweep_res_d = 1'b1;
          vec_d       = vec_q + VEC_W'(1);
          if (vec_q == LAST_VEC) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (consume_c) begin
          sweep_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vec_q       <= '0;
      y_q         <= '0;
      err_q       <= 1'b0;
      valid_q     <= 1'b0;
      sweep_res_q <= 1'b0;
      sig_q       <= '0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      y_q         <= y_d;
      err_q       <= err_d;
      valid_q     <= valid_d;
      sweep_res_q <= sweep_res_d;
      sig_q       <= sig_d;
    end
  end

  assign out_valid  = valid_q;
  assign y          = y_q;
  assign out_err    = err_q;
  assign sweep_busy = (state_q != IDLE);
  assign signature  = sig_q;

endmodule

// File: tb/tb_logic_gate_unit.sv
// Scoreboard bench for logic_gate_unit: the driver queues expected results as
// beats/sweeps are accepted, the monitor pops and compares on each consumption.
module tb_logic_gate_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  y;
  logic        out_err;
  logic        sweep_start;
  logic        sweep_busy;
  logic        sweep_done;
  logic [15:0] signature;

  always #5 clk = ~clk;

  logic_gate_unit #(.WIDTH(8), .SIG_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .out_err(out_err), .sweep_start(sweep_start),
    .sweep_busy(sweep_busy), .sweep_done(sweep_done), .signature(signature)
  );

  typedef struct {
    logic [7:0] y;
    logic       err;
    logic       last;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   rmode = 0;   // 0: out_ready high, 1: low, 2: random

  // Hand-written truth tables, bit index = {A,B}.
  logic [3:0] tt [7] = '{4'b1000, 4'b1110, 4'b0011, 4'b0111, 4'b0001, 4'b0110, 4'b1001};
  logic [7:0] e34 [7] = '{8'hC0, 8'hFC, 8'h0F, 8'h3F, 8'h03, 8'h3C, 8'hC3};

  logic       hold_p = 1'b0;
  logic [7:0] hold_y;
  logic       hold_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_sig();
    logic [15:0] s = '0;
    for (int v = 0; v < 28; v++) begin
      logic [1:0] ab;
      logic [7:0] yy;
      ab = 2'(v % 4);
      yy = tt[v / 4][ab] ? 8'hFF : 8'h00;
      s  = {s[14:0], s[15]} ^ {8'h00, yy};
    end
    return s;
  endfunction

  // Downstream readiness generator.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      #1;
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: sample just before each rising edge.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      #4;
      if (!rst_n) begin
        hold_p = 1'b0;
      end else begin
        if (hold_p) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_y", 32'(y), 32'(hold_y));
          chk("hold_err", 32'(out_err), 32'(hold_e));
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got y=%0h with nothing expected", y);
          end else begin
            e = sb.pop_front();
            chk("y", 32'(y), 32'(e.y));
            chk("out_err", 32'(out_err), 32'(e.err));
            chk("sweep_done", 32'(sweep_done), 32'(e.last));
          end
        end else if (sweep_done) begin
          chk("sweep_done_stray", 32'(sweep_done), 32'd0);
        end
        hold_p = out_valid && !out_ready;
        hold_y = y;
        hold_e = out_err;
      end
    end
  end

  // Called at a falling edge; returns on a falling edge after acceptance.
  task automatic issue(input logic [2:0] o, input logic [7:0] ia, input logic [7:0] ib,
                       input logic [7:0] ey, input logic ee, output int waited);
    bit got = 0;
    waited = 0;
    in_valid = 1'b1; op = o; a = ia; b = ib;
    for (int i = 0; i < 60 && !got; i++) begin
      #4;
      if (in_ready) begin
        got = 1;
        sb.push_back('{ey, ee, 1'b0});
      end else begin
        waited++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL issue_timeout: beat op=%0d not accepted, waited %0d", o, waited);
    end
  endtask

  task automatic start_sweep();
    sweep_start = 1'b1;
    #4;
    if (!sweep_busy) begin
      for (int v = 0; v < 28; v++) begin
        logic [1:0] ab;
        ab = 2'(v % 4);
        sb.push_back('{tt[v / 4][ab] ? 8'hFF : 8'h00, 1'b0, (v == 27)});
      end
    end
    @(negedge clk);
    sweep_start = 1'b0;
  endtask

  task automatic run_sweep(output int busy_cycles);
    start_sweep();
    busy_cycles = 0;
    for (int i = 0; i < 600; i++) begin
      if (!sweep_busy) break;
      busy_cycles++;
      @(negedge clk);
    end
    chk("sweep_drained", 32'(sb.size()), 32'd0);
    chk("signature", 32'(signature), 32'(exp_sig()));
  endtask

  initial begin
    int w;
    int bc;
    rst_n = 1'b0; in_valid = 1'b0; sweep_start = 1'b0;
    op = '0; a = '0; b = '0;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);
    chk("rst_busy", 32'(sweep_busy), 32'd0);
    chk("rst_done", 32'(sweep_done), 32'd0);
    chk("rst_sig", 32'(signature), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // All legal ops back to back, then the illegal op.
    for (int i = 0; i < 7; i++) begin
      issue(3'(i), 8'hF0, 8'hCC, e34[i], 1'b0, w);
      chk("b2b_no_wait", 32'(w), 32'd0);
    end
    issue(3'd7, 8'hFF, 8'h00, 8'h00, 1'b1, w);

    // Backpressure: result held, new beat refused until out_ready returns.
    rmode = 1;
    in_valid = 1'b1; op = 3'd5; a = 8'h55; b = 8'h0F;
    for (int i = 0; i < 5; i++) begin
      #4;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    rmode = 0;
    issue(3'd5, 8'h55, 8'h0F, 8'h5A, 1'b0, w);
    chk("bp_release_same_cycle", 32'(w), 32'd0);
    issue(3'd2, 8'h3C, 8'hFF, 8'hC3, 1'b0, w);

    run_sweep(bc);
    chk("sweep_busy_cycles", 32'(bc), 32'd29);
    run_sweep(bc);
    chk("sweep2_busy_cycles", 32'(bc), 32'd29);

    rmode = 2;
    run_sweep(bc);
    rmode = 0;
    @(negedge clk);
    @(negedge clk);

    // Reset in the middle of a sweep.
    start_sweep();
    for (int i = 0; i < 10; i++) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_y", 32'(y), 32'd0);
    chk("mid_rst_err", 32'(out_err), 32'd0);
    chk("mid_rst_busy", 32'(sweep_busy), 32'd0);
    chk("mid_rst_done", 32'(sweep_done), 32'd0);
    chk("mid_rst_sig", 32'(signature), 32'd0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue(3'd6, 8'hA5, 8'h0F, 8'h55, 1'b0, w);
    chk("post_rst_first_edge", 32'(w), 32'd0);
    run_sweep(bc);
    chk("post_rst_busy_cycles", 32'(bc), 32'd29);

    for (int i = 0; i < 4; i++) @(negedge clk);
    chk("final_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
